// File: rtl/if_stage_mq_if.sv
// Instruction SRAM-like channel between the fetch stage (master) and memory (slave).
interface if_stage_mq_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, addr, wstrb, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, addr, wstrb, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_stage_mq.sv
// Pre-IF/IF stage with multiple outstanding fetches and an in-order instruction
// buffer. Redirects flush the buffer and squash in-flight responses by counting
// them into a discard counter.
module if_stage_mq #(
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          IBUF_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = 32'h1bfffffc,
    parameter int          EBUS_ADEF       = 0
) (
    input  logic          clk,
    input  logic          reset,
    if_stage_mq_if.master inst_sram,
    input  logic          ID_allow_in,
    output logic          IFreg_valid,
    output logic [79:0]   IFreg_bus,
    input  logic [33:0]   BR_BUS,
    input  logic          except_valid,
    input  logic          wb_ex,
    input  logic [31:0]   ex_entry,
    input  logic          ertn_flush,
    input  logic [31:0]   era_pc
);
    localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int IW  = $clog2(IBUF_DEPTH) + 1;
    localparam int FPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int BPW = $clog2(IBUF_DEPTH);

    typedef struct packed {
        logic [15:0] ebus;
        logic [31:0] inst;
        logic [31:0] pc;
    } ibuf_entry_t;

    logic [31:0]    pc;
    logic           redir_pend;
    logic [31:0]    redir_target;
    logic           adef_stop;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  discard;
    logic [CW-1:0]  inflight_next;

    logic [31:0]    pc_fifo [MAX_OUTSTANDING];
    logic [FPW-1:0] fifo_wr;
    logic [FPW-1:0] fifo_rd;

    ibuf_entry_t    ibuf [IBUF_DEPTH];
    logic [BPW-1:0] ibuf_head;
    logic [BPW-1:0] ibuf_tail;
    logic [IW-1:0]  ibuf_cnt;
    ibuf_entry_t    push_entry;

    logic [31:0] br_target;
    logic        br_taken;
    logic        br_stall;
    logic        ex;
    logic        ertn;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] next_addr;
    logic        addr_misaligned;
    logic        hs;
    logic        dok;
    logic        push_data;
    logic        adef_push;
    logic        ibuf_push;
    logic        ibuf_pop;

    function automatic logic [FPW-1:0] fifo_inc(input logic [FPW-1:0] p);
        return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + FPW'(1);
    endfunction

    assign {br_target, br_taken, br_stall} = BR_BUS;
    assign ex            = wb_ex & except_valid;
    assign ertn          = ertn_flush & except_valid;
    assign redirect      = ex | ertn | br_taken;
    assign redirect_addr = ex ? ex_entry : (ertn ? era_pc : br_target);

    assign next_addr       = redir_pend ? redir_target : pc + 32'd4;
    assign addr_misaligned = |next_addr[1:0];

    // Credit check: every accepted request already owns an IBUF slot, so data_ok never stalls.
    assign inst_sram.req   = ~reset & ~br_stall & ~adef_stop & ~addr_misaligned
                           & (32'(inflight) < 32'(MAX_OUTSTANDING))
                           & (32'(inflight) + 32'(ibuf_cnt) < 32'(IBUF_DEPTH));
    assign inst_sram.wr    = 1'b0;
    assign inst_sram.size  = 2'b10;
    assign inst_sram.addr  = next_addr;
    assign inst_sram.wstrb = 4'b0;
    assign inst_sram.wdata = 32'b0;

    // Responses with nothing in flight (e.g. stale ones across reset) are ignored.
    assign hs        = inst_sram.req & inst_sram.addr_ok;
    assign dok       = inst_sram.data_ok & (inflight != '0);
    assign push_data = dok & (discard == '0) & ~redirect;
    // ADEF entry waits until everything still in flight is known to be squashed.
    assign adef_push = addr_misaligned & ~adef_stop & ~redirect & (inflight == discard)
                     & (32'(ibuf_cnt) < 32'(IBUF_DEPTH));
    assign ibuf_push = push_data | adef_push;

    assign IFreg_valid = (ibuf_cnt != '0) & ~redirect;
    assign IFreg_bus   = ibuf[ibuf_head];
    assign ibuf_pop    = IFreg_valid & ID_allow_in;

    // Entry to push: a normal fetched instruction or a synthesized ADEF marker.
    always_comb begin
        push_entry.ebus = '0;
        push_entry.inst = inst_sram.rdata;
        push_entry.pc   = pc_fifo[fifo_rd];
        if (adef_push) begin
            push_entry.ebus = 16'b1 << EBUS_ADEF;
            push_entry.inst = '0;
            push_entry.pc   = next_addr;
        end
    end

    // Next in-flight count: +1 on accept, -1 on response, unchanged when both.
    always_comb begin
        inflight_next = inflight;
        if (hs && !dok)      inflight_next = inflight + CW'(1);
        else if (!hs && dok) inflight_next = inflight - CW'(1);
    end

    // PC, pending redirect target and ADEF halt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            redir_pend   <= 1'b0;
            redir_target <= '0;
            adef_stop    <= 1'b0;
        end else begin
            if (hs || adef_push) pc <= next_addr;
            if (redirect) begin
                redir_pend   <= 1'b1;
                redir_target <= redirect_addr;
                adef_stop    <= 1'b0;
            end else if (hs || adef_push) begin
                redir_pend <= 1'b0;
                if (adef_push) adef_stop <= 1'b1;
            end
        end
    end

    // In-flight and discard counters; a redirect squashes everything still outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect)                  discard <= inflight_next;
            else if (dok && discard != '0) discard <= discard - CW'(1);
        end
    end

    // PC FIFO: address of each accepted request, consumed in response order.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_wr <= '0;
            fifo_rd <= '0;
        end else begin
            if (hs) begin
                pc_fifo[fifo_wr] <= next_addr;
                fifo_wr          <= fifo_inc(fifo_wr);
            end
            if (dok) fifo_rd <= fifo_inc(fifo_rd);
        end
    end

    // Instruction buffer: in-order ring, emptied on redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IBUF_DEPTH; i++) ibuf[i] <= '0;
            ibuf_head <= '0;
            ibuf_tail <= '0;
            ibuf_cnt  <= '0;
        end else if (redirect) begin
            ibuf_head <= '0;
            ibuf_tail <= '0;
            ibuf_cnt  <= '0;
        end else begin
            if (ibuf_push) begin
                ibuf[ibuf_tail] <= push_entry;
                ibuf_tail       <= ibuf_tail + BPW'(1);
            end
            if (ibuf_pop) ibuf_head <= ibuf_head + BPW'(1);
            if (ibuf_push && !ibuf_pop)      ibuf_cnt <= ibuf_cnt + IW'(1);
            else if (!ibuf_push && ibuf_pop) ibuf_cnt <= ibuf_cnt - IW'(1);
        end
    end
endmodule

// File: tb/tb_if_stage_mq.sv
// Bench for if_stage_mq: randomized SRAM slave plus a program-order model of
// the instruction stream ID should see (sequential from each redirect target,
// or one ADEF marker for a misaligned target).
module tb_if_stage_mq;
    localparam int MO    = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_allow_in;
    logic        IFreg_valid;
    logic [79:0] IFreg_bus;
    logic [33:0] BR_BUS;
    logic        except_valid;
    logic        wb_ex;
    logic [31:0] ex_entry;
    logic        ertn_flush;
    logic [31:0] era_pc;

    always #5 clk = ~clk;

    if_stage_mq_if bus ();

    if_stage_mq #(.MAX_OUTSTANDING(MO), .IBUF_DEPTH(DEPTH),
                  .RESET_PC(32'h1bfffffc), .EBUS_ADEF(0)) dut (
        .clk(clk), .reset(reset), .inst_sram(bus),
        .ID_allow_in(ID_allow_in), .IFreg_valid(IFreg_valid), .IFreg_bus(IFreg_bus),
        .BR_BUS(BR_BUS), .except_valid(except_valid), .wb_ex(wb_ex), .ex_entry(ex_entry),
        .ertn_flush(ertn_flush), .era_pc(era_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus knobs
    int          aok_rate = 100, allow_rate = 100, lat_min = 2, lat_max = 2;
    logic        k_ex = 0, k_ertn = 0, k_br = 0, k_ev = 0, k_stall = 0;
    logic [31:0] k_ex_entry = 0, k_era = 0, k_br_tgt = 0;

    // slave and model state
    resp_t       resp_q[$];
    int          cyc = 0;
    logic [31:0] exp_pc, exp_fetch, first_pc, watch_addr = 32'hffffffff;
    bit          adef_done, first_pending, watch_hit;
    int          adef_cnt = 0, delivered = 0;
    logic        obs_valid, obs_req, obs_hs, obs_dok;
    logic [79:0] obs_bus;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // One clock: drive inputs at negedge, observe, update slave and model.
    task automatic step();
        bit          redir;
        logic [31:0] tgt;
        logic [79:0] exp_bus;
        resp_t       r;
        @(negedge clk);
        bus.addr_ok = ($urandom_range(99) < aok_rate);
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            bus.data_ok = 1'b1;
            bus.rdata   = memf(resp_q[0].addr);
        end else begin
            bus.data_ok = 1'b0;
            bus.rdata   = $urandom;
        end
        ID_allow_in  = ($urandom_range(99) < allow_rate);
        BR_BUS       = {k_br_tgt, k_br, k_stall};
        wb_ex        = k_ex;
        ertn_flush   = k_ertn;
        except_valid = k_ev;
        ex_entry     = k_ex_entry;
        era_pc       = k_era;
        #1;
        obs_valid = IFreg_valid;
        obs_bus   = IFreg_bus;
        obs_req   = bus.req;
        obs_hs    = bus.req & bus.addr_ok;
        obs_dok   = bus.data_ok;
        redir = ((k_ex | k_ertn) & k_ev) | k_br;
        tgt   = (k_ex & k_ev) ? k_ex_entry : ((k_ertn & k_ev) ? k_era : k_br_tgt);

        if (k_stall) begin
            n_checks++;
            if (obs_req !== 1'b0) begin
                n_fail++; $display("FAIL req_under_stall: got %b expected 0", obs_req);
            end
        end
        if (obs_dok) void'(resp_q.pop_front());
        if (obs_hs) begin
            n_checks++;
            if (exp_fetch[1:0] != 2'b00 || bus.addr !== exp_fetch) begin
                n_fail++;
                $display("FAIL fetch_addr: got %h expected %h", bus.addr, exp_fetch);
            end
            if (bus.addr === watch_addr) watch_hit = 1;
            r.addr = bus.addr;
            r.due  = cyc + int'($urandom_range(lat_max, lat_min));
            resp_q.push_back(r);
            exp_fetch = bus.addr + 32'd4;
            n_checks++;
            if (resp_q.size() > MO) begin
                n_fail++; $display("FAIL inflight_bound: got %0d expected <= %0d", resp_q.size(), MO);
            end
        end

        if (redir) begin
            n_checks++;
            if (obs_valid !== 1'b0) begin
                n_fail++; $display("FAIL valid_in_redirect: got %b expected 0", obs_valid);
            end
        end
        if (obs_valid === 1'b1 && ID_allow_in) begin
            n_checks++;
            if (adef_done) begin
                n_fail++; $display("FAIL extra_after_adef: got pc %h expected none", obs_bus[31:0]);
            end else begin
                if (exp_pc[1:0] != 2'b00) begin
                    exp_bus   = {16'h0001, 32'h0, exp_pc};
                    adef_done = 1;
                    adef_cnt++;
                end else begin
                    exp_bus = {16'h0000, memf(exp_pc), exp_pc};
                    exp_pc  = exp_pc + 32'd4;
                end
                if (obs_bus !== exp_bus) begin
                    n_fail++; $display("FAIL ifreg_bus: got %h expected %h", obs_bus, exp_bus);
                end
            end
            if (first_pending) begin
                first_pc      = obs_bus[31:0];
                first_pending = 0;
            end
            delivered++;
        end
        if (redir) begin
            exp_pc        = tgt;
            exp_fetch     = tgt;
            adef_done     = 0;
            first_pending = 1;
        end
        k_ex = 0; k_ertn = 0; k_br = 0; k_ev = 0;
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.addr_ok = 0; bus.data_ok = 0; bus.rdata = 0; ID_allow_in = 0;
        BR_BUS = '0; wb_ex = 0; ertn_flush = 0; except_valid = 0; ex_entry = 0; era_pc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (bus.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.req); end
        n_checks++;
        if (IFreg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", IFreg_valid); end
        n_checks++;
        if (IFreg_bus !== 80'h0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", IFreg_bus); end
        resp_q.delete();
        reset = 1'b0; #1;
        n_checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h1c000000) begin
            n_fail++; $display("FAIL first_req: got req %b addr %h expected 1 1c000000", bus.req, bus.addr);
        end
        exp_pc = 32'h1c000000; exp_fetch = 32'h1c000000;
        adef_done = 0; first_pending = 1;
    endtask

    task automatic test_stream();
        int gaps = 0;
        aok_rate = 100; allow_rate = 100; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i >= 10 && obs_valid !== 1'b1) gaps++;
        end
        n_checks++;
        if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
        n_checks++;
        if (first_pc !== 32'h1c000000) begin n_fail++; $display("FAIL stream_first: got %h expected 1c000000", first_pc); end
    endtask

    task automatic test_backpressure();
        logic [79:0] held;
        int          unstable = 0, d0;
        allow_rate = 0;
        step();
        held = obs_bus;
        n_checks++;
        if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", obs_valid); end
        for (int i = 0; i < 9; i++) begin
            step();
            if (obs_bus !== held || obs_valid !== 1'b1) unstable++;
        end
        n_checks++;
        if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
        n_checks++;
        if (obs_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_drop: got %b expected 0", obs_req); end
        d0 = delivered;
        allow_rate = 100;
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (delivered - d0 < 15) begin n_fail++; $display("FAIL bp_resume: got %0d expected >= 15", delivered - d0); end
    endtask

    task automatic test_branch_flush();
        aok_rate = 0; allow_rate = 100;
        for (int i = 0; i < 50 && (resp_q.size() != 0 || obs_valid === 1'b1); i++) step();
        n_checks++;
        if (resp_q.size() != 0) begin n_fail++; $display("FAIL br_drain: got %0d expected 0", resp_q.size()); end
        lat_min = 8; lat_max = 8; aok_rate = 100;
        for (int i = 0; i < 20 && resp_q.size() != 3; i++) step();
        n_checks++;
        if (resp_q.size() != 3) begin n_fail++; $display("FAIL br_inflight3: got %0d expected 3", resp_q.size()); end
        aok_rate = 0; k_br = 1; k_br_tgt = 32'h1c000100;
        step();
        aok_rate = 100; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 30; i++) step();
        n_checks++;
        if (first_pc !== 32'h1c000100) begin n_fail++; $display("FAIL br_first: got %h expected 1c000100", first_pc); end
    endtask

    task automatic test_ex_vs_br();
        aok_rate = 100; allow_rate = 100; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 6; i++) step();
        watch_addr = 32'h1c000200; watch_hit = 0;
        k_ex = 1; k_ev = 1; k_ex_entry = 32'h1c008000; k_br = 1; k_br_tgt = 32'h1c000200;
        step();
        for (int i = 0; i < 30; i++) step();
        n_checks++;
        if (watch_hit) begin n_fail++; $display("FAIL ex_prio_fetch: got br target fetched expected never"); end
        n_checks++;
        if (first_pc !== 32'h1c008000) begin n_fail++; $display("FAIL ex_prio_first: got %h expected 1c008000", first_pc); end
        watch_addr = 32'hffffffff;
    endtask

    task automatic test_ertn_adef();
        int a0 = adef_cnt;
        k_ertn = 1; k_ev = 1; k_era = 32'h1c000102;
        step();
        for (int i = 0; i < 25; i++) step();
        n_checks++;
        if (adef_cnt - a0 != 1) begin n_fail++; $display("FAIL adef_count: got %0d expected 1", adef_cnt - a0); end
        n_checks++;
        if (first_pc !== 32'h1c000102) begin n_fail++; $display("FAIL adef_pc: got %h expected 1c000102", first_pc); end
        n_checks++;
        if (obs_req !== 1'b0) begin n_fail++; $display("FAIL adef_req: got %b expected 0", obs_req); end
        k_ex = 1; k_ev = 1; k_ex_entry = 32'h1c000400;
        step();
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (first_pc !== 32'h1c000400) begin n_fail++; $display("FAIL adef_resume: got %h expected 1c000400", first_pc); end
    endtask

    task automatic test_collide();
        aok_rate = 100; allow_rate = 100; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 8; i++) step();
        k_br = 1; k_br_tgt = 32'h1c000300;
        step();
        n_checks++;
        if (!(obs_hs && obs_dok)) begin
            n_fail++; $display("FAIL collide_setup: got hs %b dok %b expected 1 1", obs_hs, obs_dok);
        end
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (first_pc !== 32'h1c000300) begin n_fail++; $display("FAIL collide_first: got %h expected 1c000300", first_pc); end
    endtask

    task automatic test_random();
        int          r, d0;
        logic [31:0] t;
        d0 = delivered;
        aok_rate = 70; allow_rate = 75; lat_min = 1; lat_max = 5;
        for (int i = 0; i < 800; i++) begin
            k_stall = ($urandom_range(99) < 8);
            r = int'($urandom_range(99));
            t = 32'h1c000000 + ($urandom_range(1023) << 2) + (($urandom_range(5) == 0) ? 32'd2 : 32'd0);
            if (r < 2)      begin k_ex = 1; k_ev = 1; k_ex_entry = t; end
            else if (r < 4) begin k_ertn = 1; k_ev = 1; k_era = t; end
            else if (r < 7) begin k_br = 1; k_br_tgt = t; end
            else if (r < 9) begin k_ex = 1; k_ertn = 1; k_ev = 0; k_ex_entry = t; k_era = t; end
            step();
        end
        k_stall = 0;
        n_checks++;
        if (delivered - d0 < 100) begin n_fail++; $display("FAIL random_progress: got %0d expected >= 100", delivered - d0); end
    endtask

    task automatic test_reset_mid();
        aok_rate = 100; allow_rate = 50; lat_min = 2; lat_max = 4;
        for (int i = 0; i < 6; i++) step();
        test_reset();
        allow_rate = 100;
        for (int i = 0; i < 15; i++) step();
        n_checks++;
        if (first_pc !== 32'h1c000000) begin n_fail++; $display("FAIL reset_mid_first: got %h expected 1c000000", first_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_flush();
        test_ex_vs_br();
        test_ertn_adef();
        test_collide();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
